// File: rtl/scalar_reg_file_mp.sv
// Scalar register file with in-order write reservations, per-register pending counters and NUM_RD read ports.
// Optional same-cycle forwarding of the retiring write to readers is enabled by defining SRF_BYPASS_EN.
module scalar_reg_file_mp #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int NUM_PENDING = 4,
    parameter int NUM_RD      = 2,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int CW = $clog2(NUM_PENDING + 1),
    localparam int PW = (NUM_PENDING > 1) ? $clog2(NUM_PENDING) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [AW-1:0]                alloc_addr,
    output logic                         alloc_ready,
    input  logic                         wr_valid,
    input  logic                         wr_mask,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_REGS-1:0]          busy_vec,
    output logic [CW-1:0]                pend_count,
    output logic                         underflow_err
);

    logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];
    logic [AW-1:0]         r_fifo   [NUM_PENDING];
    logic [CW-1:0]         r_cnt    [NUM_REGS];
    logic [CW-1:0]         w_cnt_nxt[NUM_REGS];
    logic [PW-1:0]         r_head, r_tail;
    logic [NUM_REGS-1:0]   r_busy;
    logic [CW-1:0]         r_pend;
    logic                  r_under;

    logic          w_alloc_acc, w_has_pend, w_push, w_pop, w_direct, w_under;
    logic [AW-1:0] w_head_addr;
    logic [AW-1:0] w_ra;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_PENDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign alloc_ready   = (r_pend != CW'(NUM_PENDING));
    assign busy_vec      = r_busy;
    assign pend_count    = r_pend;
    assign underflow_err = r_under;

    assign w_alloc_acc = alloc_valid & alloc_ready;
    assign w_has_pend  = (r_pend != '0);
    assign w_pop       = wr_valid & w_has_pend;
    // With nothing queued, a write meeting a fresh alloc lands straight in that register.
    assign w_direct    = w_alloc_acc & wr_valid & ~w_has_pend;
    assign w_push      = w_alloc_acc & ~w_direct;
    assign w_under     = wr_valid & ~w_has_pend & ~w_alloc_acc;
    assign w_head_addr = r_fifo[r_head];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (w_push && alloc_addr == AW'(r))
                w_cnt_nxt[r] = w_cnt_nxt[r] + CW'(1);
            if (w_pop && w_head_addr == AW'(r))
                w_cnt_nxt[r] = w_cnt_nxt[r] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            for (int p = 0; p < NUM_PENDING; p++)
                r_fifo[p] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_busy  <= '0;
            r_pend  <= '0;
            r_under <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r]  <= w_cnt_nxt[r];
                r_busy[r] <= (w_cnt_nxt[r] != '0);
                if (wr_mask && ((w_pop && w_head_addr == AW'(r)) ||
                                (w_direct && alloc_addr == AW'(r))))
                    r_regs[r] <= wr_data;
            end
            if (w_push) begin
                r_fifo[r_tail] <= alloc_addr;
                r_tail         <= ptr_inc(r_tail);
            end
            if (w_pop)
                r_head <= ptr_inc(r_head);
            if (w_push && !w_pop)
                r_pend <= r_pend + CW'(1);
            else if (w_pop && !w_push)
                r_pend <= r_pend - CW'(1);
            if (w_under)
                r_under <= 1'b1;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        w_ra     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                w_ra = rd_addr[i*AW +: AW];
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ra];
                rd_valid[i] = ~r_busy[w_ra];
`ifdef SRF_BYPASS_EN
                // Forward only when the retiring write clears the register's last reservation.
                if (w_pop && wr_mask && w_head_addr == w_ra && r_cnt[w_ra] == CW'(1)) begin
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                    rd_valid[i] = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_scalar_reg_file_mp.sv
// Directed bench for scalar_reg_file_mp at default parameters (32 x 32-bit regs, 4 pending, 2 read ports).
module tb_scalar_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        alloc_ready;
    logic        wr_valid;
    logic        wr_mask;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [31:0] busy_vec;
    logic [2:0]  pend_count;
    logic        underflow_err;

    int n_vec = 0;
    int n_err = 0;

    scalar_reg_file_mp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid   (alloc_valid),
        .alloc_addr    (alloc_addr),
        .alloc_ready   (alloc_ready),
        .wr_valid      (wr_valid),
        .wr_mask       (wr_mask),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .busy_vec      (busy_vec),
        .pend_count    (pend_count),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic e0, input logic [4:0] a1, input logic e1);
        rd_addr = {a1, a0};
        rd_en   = {e1, e0};
        #1;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic wr(input logic m, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_mask  = m;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_addr = '0; wr_valid = 1'b0;
        wr_mask = 1'b0; wr_data = '0; rd_en = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and read of reg 5
        rd(5'd5, 1'b1, 5'd0, 1'b0);
        check("rst_rd_data0", rd_data[31:0], 32'h0);
        check("rst_rd_valid", rd_valid, 2'b01);
        check("rst_busy", busy_vec, 32'h0);
        check("rst_alloc_ready", alloc_ready, 1'b1);
        check("rst_pend", pend_count, 3'd0);
        check("rst_underflow", underflow_err, 1'b0);

        // Reserve reg 3, then retire with data
        alloc(5'd3);
        rd(5'd3, 1'b1, 5'd0, 1'b0);
        check("a3_busy", busy_vec, 32'h0000_0008);
        check("a3_pend", pend_count, 3'd1);
        check("a3_rd_valid_busy", rd_valid, 2'b00);
        rd(5'd0, 1'b0, 5'd0, 1'b0);
        wr(1'b1, 32'h40A0_0000);
        rd(5'd3, 1'b1, 5'd0, 1'b0);
        check("w3_busy", busy_vec, 32'h0);
        check("w3_pend", pend_count, 3'd0);
        check("w3_rd_data", rd_data[31:0], 32'h40A0_0000);
        check("w3_rd_valid", rd_valid, 2'b01);

        // Fill queue with 1,2,1,4 (pointers wrap); fifth alloc ignored
        alloc(5'd1); alloc(5'd2); alloc(5'd1); alloc(5'd4);
        check("full_alloc_ready", alloc_ready, 1'b0);
        check("full_pend", pend_count, 3'd4);
        check("full_busy", busy_vec, 32'h0000_0016);
        alloc(5'd9);
        check("ovf_pend", pend_count, 3'd4);
        check("ovf_busy", busy_vec, 32'h0000_0016);
        rd(5'd0, 1'b0, 5'd1, 1'b1);
        check("full_rd1_valid", rd_valid, 2'b00);
        rd(5'd0, 1'b0, 5'd0, 1'b0);
        wr(1'b1, 32'd10);
        check("wr10_busy", busy_vec, 32'h0000_0016);
        check("wr10_alloc_ready", alloc_ready, 1'b1);
        wr(1'b1, 32'd20);
        check("wr20_busy", busy_vec, 32'h0000_0012);
        wr(1'b1, 32'd30);
        check("wr30_busy", busy_vec, 32'h0000_0010);
        wr(1'b1, 32'd40);
        check("wr40_busy", busy_vec, 32'h0);
        check("wr40_pend", pend_count, 3'd0);
        rd(5'd1, 1'b1, 5'd2, 1'b1);
        check("reg1_2_data", rd_data, {32'd20, 32'd30});
        check("reg1_2_valid", rd_valid, 2'b11);
        rd(5'd4, 1'b1, 5'd4, 1'b0);
        check("reg4_data", rd_data, {32'd0, 32'd40});
        check("reg4_valid", rd_valid, 2'b01);

        // Simultaneous push/pop of the same register, then masked-off retire
        alloc(5'd6);
        alloc_valid = 1'b1; alloc_addr = 5'd6;
        wr(1'b1, 32'hDEAD_BEEF);
        alloc_valid = 1'b0;
        check("pp_pend", pend_count, 3'd1);
        check("pp_busy", busy_vec, 32'h0000_0040);
        wr(1'b0, 32'h1234_5678);
        rd(5'd6, 1'b1, 5'd0, 1'b0);
        check("mask0_busy", busy_vec, 32'h0);
        check("reg6_data", rd_data[31:0], 32'hDEAD_BEEF);

        // Empty queue: alloc and write together go straight to the register
        alloc_valid = 1'b1; alloc_addr = 5'd8;
        wr(1'b1, 32'h77);
        alloc_valid = 1'b0;
        rd(5'd0, 1'b0, 5'd8, 1'b1);
        check("direct_pend", pend_count, 3'd0);
        check("direct_busy", busy_vec, 32'h0);
        check("direct_underflow", underflow_err, 1'b0);
        check("direct_rd_data1", rd_data[63:32], 32'h77);
        check("direct_rd_valid", rd_valid, 2'b10);

        // Read during retiring write of reg 7 on port 1
        alloc(5'd7);
        wr_valid = 1'b1; wr_mask = 1'b1; wr_data = 32'h55;
        rd(5'd0, 1'b0, 5'd7, 1'b1);
`ifdef SRF_BYPASS_EN
        check("byp_rd_data1", rd_data[63:32], 32'h55);
        check("byp_rd_valid", rd_valid, 2'b10);
`else
        check("nobyp_rd_valid", rd_valid, 2'b00);
`endif
        step();
        wr_valid = 1'b0;
        rd(5'd0, 1'b0, 5'd7, 1'b1);
        check("reg7_data", rd_data[63:32], 32'h55);
        check("reg7_valid", rd_valid, 2'b10);

        // Underflow: write with nothing reserved
        rd(5'd0, 1'b0, 5'd0, 1'b0);
        wr(1'b1, 32'h99);
        check("uf_flag", underflow_err, 1'b1);
        check("uf_pend", pend_count, 3'd0);
        rd(5'd7, 1'b1, 5'd3, 1'b1);
        check("uf_no_write", rd_data, {32'h40A0_0000, 32'h55});
        step();
        check("uf_sticky", underflow_err, 1'b1);

        // Mid-cycle asynchronous reset with two reservations pending
        alloc(5'd10); alloc(5'd11);
        check("pre_rst_pend", pend_count, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pend", pend_count, 3'd0);
        check("arst_busy", busy_vec, 32'h0);
        check("arst_underflow", underflow_err, 1'b0);
        check("arst_alloc_ready", alloc_ready, 1'b1);
        check("arst_rd_data", rd_data, 64'h0);
        check("arst_rd_valid", rd_valid, 2'b11);
        #2 rst_n = 1'b1;
        step();
        wr(1'b1, 32'hABCD);
        check("post_rst_underflow", underflow_err, 1'b1);
        check("post_rst_pend", pend_count, 3'd0);
        rd(5'd10, 1'b1, 5'd11, 1'b1);
        check("post_rst_regs", rd_data, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
